// File: rtl/range_rng_pkg.sv
// Shared constants for the bounded random-number generator: FSM encodings,
// default seed and maximal-length LFSR tap masks per supported width.
package range_rng_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [31:0] DEFAULT_SEED = 32'h0000_ACE1;

    // Bit i set means stage i+1 feeds the XOR; masks come from primitive polynomials.
    function automatic logic [31:0] tap_mask(input int width);
        case (width)
            8:       return 32'h0000_00B8;  // x^8  + x^6  + x^5 + x^4 + 1
            16:      return 32'h0000_D008;  // x^16 + x^15 + x^13 + x^4 + 1
            24:      return 32'h00E1_0000;  // x^24 + x^23 + x^22 + x^17 + 1
            32:      return 32'h8020_0003;  // x^32 + x^22 + x^2 + x + 1
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic bit width_supported(input int width);
        return (width == 8) || (width == 16) || (width == 24) || (width == 32);
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Free-running Fibonacci LFSR: reload on restart, step while run is high, hold otherwise.
module lfsr_core
    import range_rng_pkg::*;
#(
    parameter int              WIDTH = 16,
    parameter logic [WIDTH-1:0] SEED = WIDTH'(DEFAULT_SEED)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             restart,
    input  logic             run,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] MASK   = WIDTH'(tap_mask(WIDTH));
    // An all-zero state would never leave zero, so a zero seed is replaced by 1.
    localparam logic [WIDTH-1:0] RELOAD = (SEED == '0) ? WIDTH'(1) : SEED;

    logic feedback;

    assign feedback = ^(value & MASK);

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            value <= RELOAD;
        end else if (restart) begin
            value <= RELOAD;
        end else if (run) begin
            value <= {value[WIDTH-2:0], feedback};
        end
    end

endmodule

// File: rtl/range_rng.sv
// Bounded random-number generator: captures an LFSR sample on request and reduces it
// into [offset, limit] with a bit-serial restoring remainder, one bit per cycle.
module range_rng
    import range_rng_pkg::*;
#(
    parameter int              WIDTH = 16,
    parameter logic [WIDTH-1:0] SEED = WIDTH'(DEFAULT_SEED)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             restart,
    input  logic             run,
    input  logic             req,
    input  logic [WIDTH-1:0] offset,
    input  logic [WIDTH-1:0] limit,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] out,
    output logic             range_err
);

    localparam int CNT_W = $clog2(WIDTH);

    if (!width_supported(WIDTH)) begin : g_bad_width
        $error("range_rng: unsupported WIDTH %0d (use 8, 16, 24 or 32)", WIDTH);
    end

    logic [WIDTH-1:0] lfsr_value;

    lfsr_core #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_lfsr (
        .CLK     (CLK),
        .RST     (RST),
        .restart (restart),
        .run     (run),
        .value   (lfsr_value)
    );

    logic [1:0]       state;
    logic [WIDTH-1:0] val;
    logic [WIDTH-1:0] off;
    logic [WIDTH-1:0] lim;
    logic [WIDTH:0]   span;
    logic [CNT_W-1:0] cnt;
    logic             err;
    // The remainder is always below span <= 2^WIDTH, so WIDTH bits hold it exactly.
    logic [WIDTH-1:0] rem;

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_next;

    // NOTE: every always_comb output gets a default first, so no latch can be inferred.
    always_comb begin
        trial    = {rem, val[cnt]};
        rem_next = trial[WIDTH-1:0];
        if (trial >= span) begin
            rem_next = WIDTH'(trial - span);
        end
    end

    assign ready = (state == ST_IDLE);

    // NOTE: datapath registers are reset as well, so an aborted request leaves nothing stale.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= ST_IDLE;
            val       <= '0;
            off       <= '0;
            lim       <= '0;
            span      <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            rem       <= '0;
            valid     <= 1'b0;
            out       <= '0;
            range_err <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        val   <= lfsr_value;
                        off   <= offset;
                        lim   <= limit;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Full range yields span = 2^WIDTH; the error case still iterates for fixed latency.
                    span  <= {1'b0, lim} - {1'b0, off} + (WIDTH+1)'(1);
                    err   <= (lim < off);
                    rem   <= '0;
                    cnt   <= CNT_W'(WIDTH - 1);
                    state <= ST_DIV;
                end
                ST_DIV: begin
                    rem <= rem_next;
                    if (cnt == '0) begin
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    out       <= err ? off : off + rem;
                    range_err <= err;
                    valid     <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_range_rng.sv
// Self-checking bench for range_rng: directed boundary cases plus randomized requests
// against an arithmetic reference (captured LFSR value mod span, plus offset).
module tb_range_rng;

    localparam int          W    = 16;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          LAT  = W + 2;

    logic        CLK     = 1'b0;
    logic        RST     = 1'b1;
    logic        restart = 1'b0;
    logic        run     = 1'b0;
    logic        req     = 1'b0;
    logic [15:0] offset  = '0;
    logic [15:0] limit   = '0;
    logic        ready;
    logic        valid;
    logic [15:0] out;
    logic        range_err;

    int n_checks = 0;
    int n_pass   = 0;

    range_rng #(
        .WIDTH (W),
        .SEED  (SEED)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .restart   (restart),
        .run       (run),
        .req       (req),
        .offset    (offset),
        .limit     (limit),
        .ready     (ready),
        .valid     (valid),
        .out       (out),
        .range_err (range_err)
    );

    always #5 CLK = ~CLK;

    // Reference LFSR: polynomial x^16 + x^15 + x^13 + x^4 + 1, shifting toward the MSB.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        int   taps [4] = '{16, 15, 13, 4};
        logic fb       = 1'b0;
        foreach (taps[i]) fb ^= s[taps[i]-1];
        return {s[14:0], fb};
    endfunction

    logic [15:0] mdl_lfsr;

    always @(posedge CLK or negedge RST) begin
        if (!RST)         mdl_lfsr <= SEED;
        else if (restart) mdl_lfsr <= SEED;
        else if (run)     mdl_lfsr <= lfsr_next(mdl_lfsr);
    end

    function automatic void model(input logic [15:0] v, input logic [15:0] off,
                                  input logic [15:0] lim, output logic [15:0] eo,
                                  output logic ee);
        longint span;
        if (lim < off) begin
            eo = off;
            ee = 1'b1;
        end else begin
            span = longint'(lim) - longint'(off) + 1;
            eo   = 16'(longint'(off) + (longint'(v) % span));
            ee   = 1'b0;
        end
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issues one request and watches a bounded window for the result pulse.
    task automatic issue(input logic [15:0] off, input logic [15:0] lim, input bit hold,
                         output logic rdy, output int lat, output int pulses,
                         output logic [15:0] got, output logic got_err,
                         output logic [15:0] cap);
        rdy    = ready;
        cap    = mdl_lfsr;
        offset = off;
        limit  = lim;
        req    = 1'b1;
        tick();
        if (!hold) req = 1'b0;
        offset  = 16'($urandom);
        limit   = 16'($urandom);
        lat     = -1;
        pulses  = 0;
        got     = 'x;
        got_err = 1'bx;
        for (int k = 1; k <= LAT + 4; k++) begin
            tick();
            if (valid === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat     = k;
                    got     = out;
                    got_err = range_err;
                    req     = 1'b0;
                end
            end
        end
        req = 1'b0;
    endtask

    task automatic test_reset();
        #2 RST = 1'b0;
        #1;
        n_checks++;
        if ({ready, valid, out, range_err} !== {1'b1, 1'b0, 16'h0000, 1'b0})
            $display("FAIL reset_async: ready=%b valid=%b out=%h err=%b, want 1 0 0000 0",
                     ready, valid, out, range_err);
        else n_pass++;
        tick();
        tick();
        RST = 1'b1;
        tick();
        n_checks++;
        if ({ready, valid} !== 2'b10)
            $display("FAIL reset_release: ready=%b valid=%b, want 1 0", ready, valid);
        else n_pass++;
    endtask

    task automatic test_restart_basic();
        logic rdy, ge;
        int lat, pulses;
        logic [15:0] got, cap;
        run     = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        issue(16'd10, 16'd20, 1'b1, rdy, lat, pulses, got, ge, cap);
        n_checks++;
        if (rdy !== 1'b1) $display("FAIL basic_ready: got %b want 1", rdy);
        else n_pass++;
        n_checks++;
        if (lat != LAT) $display("FAIL basic_latency: got %0d want %0d", lat, LAT);
        else n_pass++;
        n_checks++;
        if (pulses != 1) $display("FAIL basic_single_result: got %0d pulses want 1", pulses);
        else n_pass++;
        n_checks++;
        if (got !== 16'd14 || ge !== 1'b0)
            $display("FAIL basic_value: out=%0d err=%b want 14 0", got, ge);
        else n_pass++;
        n_checks++;
        if (ready !== 1'b1) $display("FAIL basic_idle_after: ready=%b want 1", ready);
        else n_pass++;
    endtask

    task automatic test_full_range();
        logic rdy, ge;
        int lat, pulses;
        logic [15:0] got, cap;
        issue(16'h0000, 16'hFFFF, 1'b0, rdy, lat, pulses, got, ge, cap);
        n_checks++;
        if (got !== SEED || ge !== 1'b0 || lat != LAT)
            $display("FAIL full_range: out=%h err=%b lat=%0d want %h 0 %0d", got, ge, lat, SEED, LAT);
        else n_pass++;
    endtask

    task automatic test_boundaries();
        logic rdy, ge;
        int lat, pulses;
        logic [15:0] got, cap;
        issue(16'h1234, 16'h1234, 1'b0, rdy, lat, pulses, got, ge, cap);
        n_checks++;
        if (got !== 16'h1234 || ge !== 1'b0 || lat != LAT)
            $display("FAIL span_one: out=%h err=%b lat=%0d want 1234 0 %0d", got, ge, lat, LAT);
        else n_pass++;
        issue(16'd50, 16'd40, 1'b0, rdy, lat, pulses, got, ge, cap);
        n_checks++;
        if (got !== 16'd50 || ge !== 1'b1)
            $display("FAIL range_err: out=%0d err=%b want 50 1", got, ge);
        else n_pass++;
        n_checks++;
        if (lat != LAT || pulses != 1)
            $display("FAIL range_err_latency: lat=%0d pulses=%0d want %0d 1", lat, pulses, LAT);
        else n_pass++;
    endtask

    task automatic test_random();
        logic rdy, ge, ee;
        int lat, pulses, kind;
        logic [15:0] got, cap, a, b, off, lim, eo;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                restart = 1'b1;
                tick();
                restart = 1'b0;
            end
            run  = 1'($urandom_range(0, 1));
            a    = 16'($urandom);
            b    = 16'($urandom);
            kind = $urandom_range(0, 4);
            case (kind)
                0:       begin off = a; lim = a; end
                1:       begin off = (a > b) ? a : b; lim = (a > b) ? b : a; end
                2:       begin off = 16'h0000; lim = 16'hFFFF; end
                default: begin off = (a < b) ? a : b; lim = (a < b) ? b : a; end
            endcase
            issue(off, lim, 1'($urandom_range(0, 1)), rdy, lat, pulses, got, ge, cap);
            model(cap, off, lim, eo, ee);
            n_checks++;
            if (got !== eo || ge !== ee || lat != LAT || pulses != 1)
                $display("FAIL random[%0d]: out=%h err=%b lat=%0d pulses=%0d want %h %b %0d 1 (val=%h off=%h lim=%h)",
                         i, got, ge, lat, pulses, eo, ee, LAT, val_str(cap), off, lim);
            else n_pass++;
        end
        run = 1'b0;
    endtask

    function automatic logic [15:0] val_str(input logic [15:0] v);
        return v;
    endfunction

    task automatic test_distribution();
        logic rdy, ge, ee;
        int lat, pulses;
        int hist [8];
        logic [15:0] got, cap, eo;
        foreach (hist[i]) hist[i] = 0;
        run = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            issue(16'd100, 16'd107, 1'b0, rdy, lat, pulses, got, ge, cap);
            model(cap, 16'd100, 16'd107, eo, ee);
            n_checks++;
            if (got !== eo || ge !== 1'b0 || lat != LAT)
                $display("FAIL dist_value[%0d]: out=%0d err=%b lat=%0d want %0d 0 %0d",
                         i, got, ge, lat, eo, LAT);
            else n_pass++;
            n_checks++;
            if (got < 16'd100 || got > 16'd107 || $isunknown(got))
                $display("FAIL dist_range[%0d]: out=%0d want 100..107", i, got);
            else begin
                n_pass++;
                hist[got - 16'd100]++;
            end
        end
        run = 1'b0;
        foreach (hist[i]) begin
            n_checks++;
            if (hist[i] < 90) $display("FAIL dist_bin[%0d]: hits=%0d want >=90", 100 + i, hist[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic rdy, ge, ee;
        int lat, pulses;
        logic [15:0] got, cap, eo;
        offset = 16'd0;
        limit  = 16'd999;
        req    = 1'b1;
        tick();
        req = 1'b0;
        repeat (6) tick();
        #3 RST = 1'b0;
        #1;
        n_checks++;
        if ({ready, valid, out, range_err} !== {1'b1, 1'b0, 16'h0000, 1'b0})
            $display("FAIL reset_mid: ready=%b valid=%b out=%h err=%b, want 1 0 0000 0",
                     ready, valid, out, range_err);
        else n_pass++;
        tick();
        tick();
        RST    = 1'b1;
        pulses = 0;
        for (int k = 0; k < LAT + 6; k++) begin
            tick();
            if (valid === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0 || ready !== 1'b1)
            $display("FAIL reset_mid_abort: pulses=%0d ready=%b want 0 1", pulses, ready);
        else n_pass++;
        issue(16'd10, 16'd20, 1'b0, rdy, lat, pulses, got, ge, cap);
        model(cap, 16'd10, 16'd20, eo, ee);
        n_checks++;
        if (got !== eo || ge !== ee || lat != LAT || pulses != 1)
            $display("FAIL reset_mid_recover: out=%0d err=%b lat=%0d want %0d %b %0d",
                     got, ge, lat, eo, ee, LAT);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_restart_basic();
        test_full_range();
        test_boundaries();
        test_random();
        test_distribution();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
